conv_out_framer: RTL and testbench

CONV_OUT_FRAMER -- requirements
Module: conv_out_framer

---
 rtl/conv_out_framer.sv | 150 +++++++++++++++
 tb/tb_conv_out_framer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_framer.sv
// conv_out_framer: frames a conv-output word stream into one layer.
// Sets the layer size on start, buffers words in a 2-entry skid FIFO and flags
// the last word (mLast). Pulses LayerEnd once the last word has been accepted.
// Optional macro CONV_OUT_RELU_EN: replaces negative int8 lanes with zero on the
// FIFO input path.
module conv_out_framer #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [15:0]           In_Channel,
   input  logic [15:0]           Matrix_Row,
   input  logic [15:0]           Matrix_Col,
   input  logic [DATA_WIDTH-1:0] sData,
   input  logic                  sValid,
   output logic                  sReady,
   output logic [DATA_WIDTH-1:0] mData_payload,
   output logic                  mData_valid,
   input  logic                  mData_ready,
   output logic                  mLast,
   output logic                  LayerEnd
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                state_q, state_d;
   logic [15:0]           in_ch_q, in_ch_d;
   logic [15:0]           row_q, row_d;
   logic [15:0]           col_q, col_d;
   logic [CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
   logic [1:0]            count_q, count_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];

   logic [CNT_WIDTH-1:0]  total;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  push, pop, fifo_full, start_zero;

   // Layer size from the latched geometry; one word carries 8 channels.
   assign total = CNT_WIDTH'(row_q) * CNT_WIDTH'(col_q) * CNT_WIDTH'(in_ch_q >> 3);
   assign start_zero = ((In_Channel >> 3) == 16'd0) || (Matrix_Row == 16'd0) ||
                       (Matrix_Col == 16'd0);

   assign fifo_full = (count_q == 2'd2);

   // Outputs are forced low while reset is asserted, not only after it.
   assign mData_valid   = !reset && (count_q != 2'd0);
   assign mData_payload = mData_valid ? mem_q[rd_ptr_q] : '0;
   assign mLast         = mData_valid && (out_cnt_q == total - CNT_WIDTH'(1));
   assign LayerEnd      = !reset && (state_q == StDone);
   assign pop           = mData_valid && mData_ready;
   // A full FIFO still takes a word on a cycle it pops (skid behaviour).
   assign sReady        = !reset && (state_q == StRun) && (in_cnt_q < total) &&
                          (!fifo_full || pop);
   assign push          = sValid && sReady;

`ifdef CONV_OUT_RELU_EN
   localparam int unsigned Lanes = DATA_WIDTH / 8;

   // Zero every signed int8 lane that is negative before it enters the FIFO.
   always_comb begin
      push_data = sData;
      for (int unsigned i = 0; i < Lanes; i++) begin
         if (sData[8*i+7]) begin
            push_data[8*i +: 8] = 8'h00;
         end
      end
   end
`else
   assign push_data = sData;
`endif

   // Next-state for the FSM, layer counters and skid FIFO.
   always_comb begin
      state_d   = state_q;
      in_ch_d   = in_ch_q;
      row_d     = row_q;
      col_d     = col_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      mem_d     = mem_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               in_ch_d   = In_Channel;
               row_d     = Matrix_Row;
               col_d     = Matrix_Col;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               count_d   = 2'd0;
               rd_ptr_d  = 1'b0;
               wr_ptr_d  = 1'b0;
               state_d   = start_zero ? StDone : StRun;
            end
         end
         StRun: begin
            if (pop) begin
               rd_ptr_d  = ~rd_ptr_q;
               out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
               if (mLast) begin
                  state_d = StDone;
               end
            end
            if (push) begin
               mem_d[wr_ptr_q] = push_data;
               wr_ptr_d        = ~wr_ptr_q;
               in_cnt_d        = in_cnt_q + CNT_WIDTH'(1);
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset; FIFO storage needs no reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         in_ch_q   <= '0;
         row_q     <= '0;
         col_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_ch_q   <= in_ch_d;
         row_q     <= row_d;
         col_q     <= col_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_conv_out_framer.sv
// Bench for conv_out_framer: a queue-based layer model checked every cycle,
// plus literal expectations for word counts, mLast position and LayerEnd.
module tb_conv_out_framer;

   localparam int DW = 64;
   localparam int CW = 32;
   localparam logic [63:0] ReluIn = 64'h80FF7F0001FE0203;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [15:0]   in_ch, row, col;
   logic [DW-1:0] s_data;
   logic          s_valid, s_ready;
   logic [DW-1:0] m_payload;
   logic          m_valid, m_ready, m_last, layer_end;

   always #5 clk = ~clk;

   conv_out_framer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .In_Channel   (in_ch),
      .Matrix_Row   (row),
      .Matrix_Col   (col),
      .sData        (s_data),
      .sValid       (s_valid),
      .sReady       (s_ready),
      .mData_payload(m_payload),
      .mData_valid  (m_valid),
      .mData_ready  (m_ready),
      .mLast        (m_last),
      .LayerEnd     (layer_end)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Model state: words held between input and output, and layer progress.
   logic [DW-1:0] mq[$];
   int            m_mode = 0;  // 0 idle, 1 run, 2 done
   longint        m_total = 0, m_acc = 0, m_pop = 0;

   // DUT observations for literal checks.
   int            obs_words, obs_last_pos, obs_le, obs_src, obs_valid_cyc, le_cyc, start_cyc;
   logic [DW-1:0] first_payload;
   bit            saw_full;
   bit            s_fixed = 1'b0;
   int            rdy_mode = 0;

   task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] gen(input int k);
      return {32'(k) * 32'h9E3779B1, 32'(k) ^ 32'h80402010};
   endfunction

   function automatic logic [63:0] relu(input logic [63:0] w);
      logic [63:0] r = w;
`ifdef CONV_OUT_RELU_EN
      for (int i = 0; i < 8; i++) if (w[8*i+7]) r[8*i +: 8] = 8'h00;
`endif
      return r;
   endfunction

   // Compare process: check outputs against the model, then advance the model
   // by what the coming rising edge does.
   initial begin
      logic          e_valid, e_last, e_le, e_ready, pop, push;
      logic [DW-1:0] e_payload;
      logic          prev_stall = 1'b0, prev_last = 1'b0;
      logic [DW-1:0] prev_payload = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            e_valid = 0; e_payload = '0; e_last = 0; e_le = 0; e_ready = 0;
         end else begin
            e_valid   = (mq.size() != 0);
            e_payload = e_valid ? mq[0] : '0;
            e_last    = e_valid && (m_pop == m_total - 1);
            e_le      = (m_mode == 2);
            e_ready   = (m_mode == 1) && (m_acc < m_total) &&
                        (mq.size() < 2 || (e_valid && m_ready));
         end
         check("cyc_ctrl", {68'd0, s_ready, m_valid, m_last, layer_end},
               {68'd0, e_ready, e_valid, e_last, e_le});
         check("cyc_payload", {8'd0, m_payload}, {8'd0, e_payload});
         if (prev_stall) begin
            check("stall_stable", {7'd0, m_last, m_payload}, {7'd0, prev_last, prev_payload});
         end
         prev_stall   = m_valid && !m_ready;
         prev_last    = m_last;
         prev_payload = m_payload;
         // DUT-side observations
         if (m_valid) obs_valid_cyc++;
         if (m_valid && m_ready) begin
            if (obs_words == 0) first_payload = m_payload;
            obs_words++;
            if (m_last) obs_last_pos = obs_words;
         end
         if (layer_end) begin
            obs_le++;
            le_cyc = cyc;
         end
         if (s_valid && s_ready) obs_src++;
         if (!reset && m_mode == 1 && mq.size() == 2 && !s_ready) saw_full = 1'b1;
         // Model advance
         if (reset) begin
            mq.delete();
            m_mode = 0; m_acc = 0; m_pop = 0;
         end else begin
            pop  = e_valid && m_ready;
            push = e_ready && s_valid;
            if (m_mode == 2) begin
               m_mode = 0;
            end else if (m_mode == 0) begin
               if (start) begin
                  m_total = longint'(row) * longint'(col) * longint'(in_ch / 8);
                  m_acc = 0; m_pop = 0;
                  m_mode = (m_total == 0) ? 2 : 1;
               end
            end else begin
               if (pop) begin
                  if (e_last) m_mode = 2;
                  void'(mq.pop_front());
                  m_pop++;
               end
               if (push) begin
                  mq.push_back(relu(s_data));
                  m_acc++;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      s_data  = s_fixed ? ReluIn : gen(obs_src);
      m_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
   endtask

   task automatic start_layer(input logic [15:0] ch, input logic [15:0] r, input logic [15:0] c);
      obs_words = 0; obs_last_pos = 0; obs_le = 0; obs_src = 0; obs_valid_cyc = 0;
      le_cyc = 0; saw_full = 1'b0;
      s_data = s_fixed ? ReluIn : gen(0);
      in_ch = ch; row = r; col = c;
      start = 1'b1;
      start_cyc = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (obs_le == 0 && n < budget) begin
         step();
         n++;
      end
      n_tests++;
      if (obs_le == 0) begin
         n_fail++;
         $display("FAIL layer_timeout: got no LayerEnd, required one within %0d cycles", budget);
      end
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; in_ch = '0; row = '0; col = '0;
      s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
      repeat (3) step();
      check("reset_ctrl_during", {68'd0, s_ready, m_valid, m_last, layer_end}, 72'd0);
      reset = 1'b0;
      step();
      check("reset_ctrl_after", {68'd0, s_ready, m_valid, m_last, layer_end}, 72'd0);
      check("reset_payload", {8'd0, m_payload}, 72'd0);
      s_valid = 1'b1;

      // Full layer, no backpressure; excess upstream words stay unconsumed.
      start_layer(16'd32, 16'd14, 16'd14);
      wait_end(4000);
      repeat (3) step();
      check("a_words", 72'(obs_words), 72'd784);
      check("a_last_pos", 72'(obs_last_pos), 72'd784);
      check("a_layerend", 72'(obs_le), 72'd1);
      check("a_src_taken", 72'(obs_src), 72'd784);
      check("a_idle", {70'd0, s_ready, m_valid}, 72'd0);

      // Same layer with downstream ready toggling.
      rdy_mode = 1;
      start_layer(16'd32, 16'd14, 16'd14);
      wait_end(6000);
      repeat (3) step();
      check("b_words", 72'(obs_words), 72'd784);
      check("b_last_pos", 72'(obs_last_pos), 72'd784);
      check("b_ready_drop_full", 72'(saw_full), 72'd1);
      rdy_mode = 0;

      // Zero-size layer.
      start_layer(16'd0, 16'd14, 16'd14);
      wait_end(20);
      repeat (2) step();
      check("c_no_valid", 72'(obs_valid_cyc), 72'd0);
      check("c_layerend", 72'(obs_le), 72'd1);
      check("c_le_delay", 72'(le_cyc - start_cyc), 72'd2);

      // Reset in the middle of a layer, then a fresh full layer.
      start_layer(16'd32, 16'd14, 16'd14);
      n = 0;
      while (obs_words < 100 && n < 2000) begin
         step();
         n++;
      end
      check("d_reached_100", 72'(obs_words >= 100), 72'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("d_cleared_ctrl", {68'd0, s_ready, m_valid, m_last, layer_end}, 72'd0);
      check("d_cleared_payload", {8'd0, m_payload}, 72'd0);
      start_layer(16'd32, 16'd14, 16'd14);
      wait_end(4000);
      check("d_words", 72'(obs_words), 72'd784);
      check("d_last_pos", 72'(obs_last_pos), 72'd784);

      // start pulsed mid-RUN with different geometry is ignored.
      start_layer(16'd32, 16'd14, 16'd14);
      repeat (50) step();
      in_ch = 16'd8; row = 16'd1; col = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_end(4000);
      check("e_words", 72'(obs_words), 72'd784);
      check("e_last_pos", 72'(obs_last_pos), 72'd784);

      // Single-word layer carrying the lane-clamp vector.
      s_fixed = 1'b1;
      start_layer(16'd8, 16'd1, 16'd1);
      wait_end(50);
      check("f_words", 72'(obs_words), 72'd1);
      check("f_last_pos", 72'(obs_last_pos), 72'd1);
`ifdef CONV_OUT_RELU_EN
      check("f_payload", {8'd0, first_payload}, {8'd0, 64'h00007F0001000203});
`else
      check("f_payload", {8'd0, first_payload}, {8'd0, 64'h80FF7F0001FE0203});
`endif
      s_fixed = 1'b0;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
